mix_columns_engine: RTL and testbench
=====================================

# mix_columns_engine

Sequential, parametrised AES MixColumns / InvMixColumns unit for the round datapath. It accepts a full 128-bit state over a valid/ready handshake and processes LANES columns per clock. It returns the transformed state over a second valid/ready handshake. Forward mode is always present; inverse mode is enabled by parameter, so encryption and decryption rounds share one block.

## Interface
Parameters:
- LANES, default 1: columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
- INVERSE_EN, default 1: 1 enables InvMixColumns; 0 removes inverse logic and forces forward mode.

Ports:
- pi_clk  input  1  single clock; all state changes on its rising edge.
- pi_reset  input  1  asynchronous, active-high reset.
- pi_valid  input  1  input state valid.
- po_ready  output  1  engine can accept a state.
- pi_inverse  input  1  1 = InvMixColumns; sampled at accept; ignored when INVERSE_EN=0.
- pi_state  input  128  input state.
- po_valid  output  1  po_state valid.
- pi_ready  input  1  downstream accepts po_state.
- po_state  output  128  transformed state.
- po_busy  output  1  high in RUN and DONE.

## Operation
- Layout: column c (0..3) is bits [32c+31:32c]; row r (0..3) of that column is bits [32c+8r+7:32c+8r].
- Forward, per column, all indices mod 4: b_r = 02·a_r ^ 03·a_{r+1} ^ 01·a_{r+2} ^ 01·a_{r+3}.
- Inverse: b_r = 0e·a_r ^ 0b·a_{r+1} ^ 0d·a_{r+2} ^ 09·a_{r+3}.
- Multiplication is in GF(2^8) with modulus x^8+x^4+x^3+x+1. xtime(a) = (a<<1)[7:0] ^ (a[7] ? 8'h1b : 8'h00). 09, 0b, 0d and 0e are built from three chained xtime steps plus XORs. No lookup tables.
- N = 4/LANES. A 2-bit column counter col steps by LANES and wraps to 0.
- FSM states:
  - IDLE: po_ready=1. On pi_valid=1 the engine loads pi_state into the work register, latches the mode, sets col=0 and moves to RUN.
  - RUN: each cycle, columns col..col+LANES-1 are replaced in place by their transform and col advances by LANES. After the N-th RUN cycle the engine moves to DONE.
  - DONE: po_valid=1 and po_state = work register. On pi_ready=1 the engine moves to IDLE.
- po_ready is high only in IDLE. pi_valid is ignored in RUN and DONE, with no queueing.
- po_state is held stable while po_valid=1 and pi_ready=0, for any number of cycles.
- Changing pi_state or pi_inverse after the accept edge has no effect on the result in flight.
- Each column is transformed exactly once per block; untouched columns keep their loaded value until their slot.

## Timing
- Reset values: FSM=IDLE, col=0, work register=0, po_valid=0, po_busy=0, po_state=128'h0. po_ready=1 once pi_reset deasserts.
- Latency: accept at edge T means RUN cycles occupy T..T+N-1 and po_valid rises after edge T+N. Latency is 4, 2 or 1 cycles for LANES = 1, 2 or 4.
- Output handshake at edge U means po_valid falls and po_ready rises after U. The next accept can occur at edge U+1, so minimum spacing between accepts is N+2 cycles.
- pi_reset asserted in any state immediately returns the block to reset values. The in-flight block is discarded and no po_valid is produced for it.
- All outputs are registered or decoded from FSM state. No combinational path exists from pi_* to po_*.

## Test plan
- Forward, LANES=1: all four columns 32'h455313db (row0 = db) → every output column 32'hbca14d8e. po_valid rises exactly 4 cycles after accept.
- Forward, mixed columns, LANES=2: c0=32'h5c220af2, c1=32'h01010101, c2=32'hc6c6c6c6, c3=32'hd5d4d4d4 → 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6, 32'hd6d7d5d5; latency 2.
- Inverse, LANES=4: the forward outputs of the two tests above fed back in with pi_inverse=1 → the original states; latency 1. With INVERSE_EN=0 and pi_inverse=1, the result equals the forward result.
- Backpressure: hold pi_ready=0 for 10 cycles in DONE → po_state stable and po_ready=0 throughout. pi_valid pulses during that window are ignored, and the next accept happens only after the handshake.
- Reset mid-RUN (LANES=1): assert pi_reset on the 2nd RUN cycle → po_valid=0 and po_state=0 immediately. After deassert, po_ready=1, and a fresh 32'h01010101×4 state yields an identical output.
- Random regression: 1000 random states and modes across LANES ∈ {1,2,4}, compared against a software AES MixColumns model. Forward followed by inverse must round-trip to the original state.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: accepts a 128-bit state, transforms LANES
// columns per clock in place, then presents the result until downstream accepts it.
`timescale 1ns/1ps
module mix_columns_engine #(
    parameter int LANES      = 1,
    parameter int INVERSE_EN = 1
) (
    input  logic         pi_clk,
    input  logic         pi_reset,
    input  logic         pi_valid,
    output logic         po_ready,
    input  logic         pi_inverse,
    input  logic [127:0] pi_state,
    output logic         po_valid,
    input  logic         pi_ready,
    output logic [127:0] po_state,
    output logic         po_busy
);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
            $error("mix_columns_engine: LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] COL_STEP = 2'(LANES % 4);
    localparam logic [1:0] LAST_COL = 2'((4 - LANES) % 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_col;
    logic           r_inv;
    logic [127:0]   r_work;
    logic [127:0]   w_work_next;
    logic [31:0]    w_lane_out [LANES];
    logic           w_accept;
    logic           w_last;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse coefficients are composed from x2/x4/x8 of each byte.
    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
        logic [31:0] b;
        logic [7:0]  a0, a1, a2, a3;
        logic [7:0]  a1x2, a1x4, a1x8;
        logic [7:0]  a0x2, a0x4, a0x8;
        logic [7:0]  a2x2, a2x4, a2x8;
        logic [7:0]  a3x2, a3x4, a3x8;
        b = '0;
        for (int r = 0; r < 4; r++) begin
            a0 = a[8*r +: 8];
            a1 = a[8*((r + 1) % 4) +: 8];
            a2 = a[8*((r + 2) % 4) +: 8];
            a3 = a[8*((r + 3) % 4) +: 8];
            a0x2 = xtime(a0); a0x4 = xtime(a0x2); a0x8 = xtime(a0x4);
            a1x2 = xtime(a1); a1x4 = xtime(a1x2); a1x8 = xtime(a1x4);
            a2x2 = xtime(a2); a2x4 = xtime(a2x2); a2x8 = xtime(a2x4);
            a3x2 = xtime(a3); a3x4 = xtime(a3x2); a3x8 = xtime(a3x4);
            if (INVERSE_EN != 0 && inv) begin
                b[8*r +: 8] = (a0x8 ^ a0x4 ^ a0x2)
                            ^ (a1x8 ^ a1x2 ^ a1)
                            ^ (a2x8 ^ a2x4 ^ a2)
                            ^ (a3x8 ^ a3);
            end else begin
                b[8*r +: 8] = a0x2 ^ (a1x2 ^ a1) ^ a2 ^ a3;
            end
        end
        return b;
    endfunction

    assign w_accept = (r_state == S_IDLE) && pi_valid;
    assign w_last   = (r_col == LAST_COL);

    // Transform units: lane l works on column r_col + l.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [1:0] w_idx;
            assign w_idx         = r_col + 2'(l);
            assign w_lane_out[l] = mix_col(r_work[32*w_idx +: 32], r_inv);
        end
    endgenerate

    always_comb begin
        w_work_next = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_next[32*(r_col + 2'(l)) +: 32] = w_lane_out[l];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (pi_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  if (pi_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pi_clk or posedge pi_reset) begin
        if (pi_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge pi_clk or posedge pi_reset) begin
        if (pi_reset) begin
            r_col  <= 2'd0;
            r_inv  <= 1'b0;
            r_work <= '0;
        end else if (w_accept) begin
            r_col  <= 2'd0;
            r_inv  <= (INVERSE_EN != 0) ? pi_inverse : 1'b0;
            r_work <= pi_state;
        end else if (r_state == S_RUN) begin
            r_col  <= r_col + COL_STEP;
            r_work <= w_work_next;
        end
    end

    assign po_ready = (r_state == S_IDLE);
    assign po_valid = (r_state == S_DONE);
    assign po_busy  = (r_state == S_RUN) || (r_state == S_DONE);
    assign po_state = r_work;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: four instances (LANES 1/2/4, plus LANES 4 without inverse)
// driven from a vector table, hand-written corner sequences and a random regression.
`timescale 1ns/1ps
module tb_mix_columns_engine;

    logic         pi_clk;
    logic         pi_reset;
    logic [3:0]   t_vld;
    logic [3:0]   t_inv;
    logic [3:0]   t_rdy;
    logic [127:0] t_st   [4];
    logic [3:0]   o_rdy;
    logic [3:0]   o_vld;
    logic [3:0]   o_busy;
    logic [127:0] o_st   [4];

    int vectors;
    int miscompares;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int LN  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
            localparam int INV = (g == 3) ? 0 : 1;
            mix_columns_engine #(.LANES(LN), .INVERSE_EN(INV)) u_dut (
                .pi_clk    (pi_clk),
                .pi_reset  (pi_reset),
                .pi_valid  (t_vld[g]),
                .po_ready  (o_rdy[g]),
                .pi_inverse(t_inv[g]),
                .pi_state  (t_st[g]),
                .po_valid  (o_vld[g]),
                .pi_ready  (t_rdy[g]),
                .po_state  (o_st[g]),
                .po_busy   (o_busy[g])
            );
        end
    endgenerate

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Reference: generic GF(2^8) shift-and-add multiply, coefficient rows from the AES matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] o = '0;
        if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[32*c + 8*((r + j) % 4) +: 8], cf[j]);
                o[32*c + 8*r +: 8] = acc;
            end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(input int k, input logic [127:0] s, input logic inv);
        int n = 0;
        t_vld[k] = 1'b1;
        t_st[k]  = s;
        t_inv[k] = inv;
        while (!o_rdy[k] && n < 20) begin
            @(posedge pi_clk); #1; n++;
        end
        @(posedge pi_clk); #1;
        t_vld[k] = 1'b0;
        t_st[k]  = {$urandom, $urandom, $urandom, $urandom};
        t_inv[k] = ~inv;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!o_vld[k] && lat < 20) begin
            @(posedge pi_clk); #1; lat++;
        end
        if (!o_vld[k]) check("timeout_po_valid", 128'(o_vld[k]), 128'd1);
    endtask

    task automatic handshake(input int k);
        t_rdy[k] = 1'b1;
        @(posedge pi_clk); #1;
        t_rdy[k] = 1'b0;
    endtask

    task automatic run_block(input int k, input logic [127:0] s, input logic inv,
                             output logic [127:0] res, output int lat);
        start(k, s, inv);
        wait_valid(k, lat);
        res = o_st[k];
        handshake(k);
    endtask

    typedef struct {
        int           k;
        logic         inv;
        logic [127:0] in;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    localparam logic [127:0] IN1  = {4{32'h455313db}};
    localparam logic [127:0] EXP1 = {4{32'hbca14d8e}};
    localparam logic [127:0] IN2  = {32'hd5d4d4d4, 32'hc6c6c6c6, 32'h01010101, 32'h5c220af2};
    localparam logic [127:0] EXP2 = {32'hd6d7d5d5, 32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f};

    initial begin
        vec_t         tbl [7];
        logic [127:0] res, res2, s;
        logic         inv;
        int           lat, k;

        vectors = 0;
        miscompares = 0;
        t_vld = '0; t_inv = '0; t_rdy = '0;
        for (int i = 0; i < 4; i++) t_st[i] = '0;

        tbl[0] = '{0, 1'b0, IN1,  EXP1, 4};
        tbl[1] = '{1, 1'b0, IN2,  EXP2, 2};
        tbl[2] = '{2, 1'b1, EXP1, IN1,  1};
        tbl[3] = '{2, 1'b1, EXP2, IN2,  1};
        tbl[4] = '{3, 1'b1, IN1,  EXP1, 1};
        tbl[5] = '{3, 1'b1, IN2,  EXP2, 1};
        tbl[6] = '{0, 1'b1, EXP2, IN2,  4};

        pi_reset = 1'b1;
        repeat (3) @(posedge pi_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_po_valid[%0d]", i), 128'(o_vld[i]),  128'd0);
            check($sformatf("reset_po_busy[%0d]", i),  128'(o_busy[i]), 128'd0);
            check($sformatf("reset_po_state[%0d]", i), o_st[i],         128'd0);
        end
        pi_reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_po_ready[%0d]", i), 128'(o_rdy[i]), 128'd1);

        for (int i = 0; i < 7; i++) begin
            run_block(tbl[i].k, tbl[i].in, tbl[i].inv, res, lat);
            check($sformatf("tbl%0d_state", i),   res,        tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), 128'(lat),  128'(tbl[i].lat));
            check($sformatf("tbl%0d_ready", i),   128'(o_rdy[tbl[i].k]), 128'd1);
            check($sformatf("tbl%0d_valid_low", i), 128'(o_vld[tbl[i].k]), 128'd0);
        end

        // Backpressure on the LANES=2 instance with ignored pi_valid pulses.
        start(1, IN2, 1'b0);
        wait_valid(1, lat);
        check("bp_first_state", o_st[1], EXP2);
        for (int i = 0; i < 10; i++) begin
            t_vld[1] = (i % 3 == 0);
            t_st[1]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge pi_clk); #1;
            check("bp_state", o_st[1], EXP2);
            check("bp_ready", 128'(o_rdy[1]), 128'd0);
            check("bp_valid", 128'(o_vld[1]), 128'd1);
        end
        t_vld[1] = 1'b0;
        handshake(1);
        check("bp_post_ready", 128'(o_rdy[1]), 128'd1);
        check("bp_post_valid", 128'(o_vld[1]), 128'd0);
        repeat (3) @(posedge pi_clk);
        #1;
        check("bp_no_queue_busy", 128'(o_busy[1]), 128'd0);
        run_block(1, IN1, 1'b0, res, lat);
        check("bp_next_block", res, EXP1);

        // Reset on the second RUN cycle of the LANES=1 instance.
        start(0, IN1, 1'b0);
        check("rst_busy_before", 128'(o_busy[0]), 128'd1);
        @(posedge pi_clk); #1;
        pi_reset = 1'b1;
        #1;
        check("rst_mid_valid", 128'(o_vld[0]),  128'd0);
        check("rst_mid_state", o_st[0],         128'd0);
        check("rst_mid_busy",  128'(o_busy[0]), 128'd0);
        @(posedge pi_clk); #1;
        pi_reset = 1'b0;
        #1;
        check("rst_after_ready", 128'(o_rdy[0]), 128'd1);
        repeat (6) @(posedge pi_clk);
        #1;
        check("rst_no_stale_valid", 128'(o_vld[0]), 128'd0);
        run_block(0, {4{32'h01010101}}, 1'b0, res, lat);
        check("rst_fresh_block", res, {4{32'h01010101}});

        // Random regression with round trips.
        for (int i = 0; i < 1000; i++) begin
            k   = $urandom_range(0, 3);
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            run_block(k, s, inv, res, lat);
            check($sformatf("rand%0d_L%0d", i, k), res, model(s, inv && (k != 3)));
            if (i % 4 == 0) begin
                k = i % 3;
                run_block(k, s, 1'b0, res, lat);
                run_block(k, res, 1'b1, res2, lat);
                check($sformatf("roundtrip%0d_L%0d", i, k), res2, s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
